// File: rtl/clk_gate_seq_pkg.sv
// clk_gate_seq_pkg: shared domain-state type and default parameters for clk_gate_seq
package clk_gate_seq_pkg;
    typedef enum logic [2:0] {
        ST_OFF,
        ST_PEND,
        ST_WAKE,
        ST_ON,
        ST_HOLD
    } dom_state_t;
    localparam int DEF_N_DOM    = 4;
    localparam int DEF_IDLE_CYC = 16;
    localparam int DEF_WAKE_GAP = 2;
endpackage

// File: rtl/clk_gate_seq_dom.sv
// clk_gate_seq_dom: one gated-clock domain FSM with its idle hold counter
//   CLK      clock
//   RST      synchronous active-high reset
//   i_req    level-sensitive clock demand
//   i_grant  wake grant from the arbiter (only meaningful while pending)
//   o_pend   domain waits for a wake grant
//   o_en     clock gate enable (WAKE/ON/HOLD)
//   o_ack    gated clock running (ON/HOLD)
module clk_gate_seq_dom
    import clk_gate_seq_pkg::*;
#(
    parameter int IDLE_CYC = DEF_IDLE_CYC
) (
    input  logic CLK,
    input  logic RST,
    input  logic i_req,
    input  logic i_grant,
    output logic o_pend,
    output logic o_en,
    output logic o_ack
);
    localparam int CW = $clog2(IDLE_CYC + 1);

    dom_state_t    r_state, w_state_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= ST_OFF;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_OFF:  w_state_nxt = i_req ? ST_PEND : ST_OFF;
            ST_PEND: w_state_nxt = i_grant ? ST_WAKE : (i_req ? ST_PEND : ST_OFF);
            ST_WAKE: w_state_nxt = ST_ON;
            ST_ON: begin
                if (!i_req) begin
                    w_state_nxt = ST_HOLD;
                    w_cnt_nxt   = CW'(IDLE_CYC - 1);
                end
            end
            ST_HOLD: begin
                if (i_req)
                    w_state_nxt = ST_ON;
                else if (r_cnt == '0)
                    w_state_nxt = ST_OFF;
                else
                    w_cnt_nxt = r_cnt - 1'b1;
            end
            default: w_state_nxt = ST_OFF;
        endcase
    end

    assign o_pend = (r_state == ST_PEND);
    assign o_en   = (r_state == ST_WAKE) || (r_state == ST_ON) || (r_state == ST_HOLD);
    assign o_ack  = (r_state == ST_ON) || (r_state == ST_HOLD);
endmodule

// File: rtl/clk_gate_seq.sv
// clk_gate_seq: sequenced clock-gate enables with round-robin, rate-limited wake grants
//   CLK       clock for all logic
//   RST       synchronous active-high reset
//   FORCE_ON  forces every EN high (only with CLK_GATE_SEQ_FORCE_ON_EN defined)
//   REQ       per-domain clock demand
//   EN        per-domain clock gate enable
//   ACK       per-domain gated clock running
module clk_gate_seq
    import clk_gate_seq_pkg::*;
#(
    parameter int N_DOM    = DEF_N_DOM,
    parameter int IDLE_CYC = DEF_IDLE_CYC,
    parameter int WAKE_GAP = DEF_WAKE_GAP
) (
    input  logic             CLK,
    input  logic             RST,
`ifdef CLK_GATE_SEQ_FORCE_ON_EN
    input  logic             FORCE_ON,
`endif
    input  logic [N_DOM-1:0] REQ,
    output logic [N_DOM-1:0] EN,
    output logic [N_DOM-1:0] ACK
);
    localparam int PW = (N_DOM > 1) ? $clog2(N_DOM) : 1;
    localparam int GW = (WAKE_GAP > 0) ? $clog2(WAKE_GAP + 1) : 1;

    logic [N_DOM-1:0] w_pend, w_en, w_grant;
    logic [PW-1:0]    r_ptr, w_gnt_idx;
    logic [GW-1:0]    r_gap;
    logic             w_gnt_vld;

    for (genvar i = 0; i < N_DOM; i++) begin : g_dom
        clk_gate_seq_dom #(.IDLE_CYC(IDLE_CYC)) u_dom (
            .CLK     (CLK),
            .RST     (RST),
            .i_req   (REQ[i]),
            .i_grant (w_grant[i]),
            .o_pend  (w_pend[i]),
            .o_en    (w_en[i]),
            .o_ack   (ACK[i])
        );
    end

    // first pending domain at or after the pointer, blocked while the gap runs
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_idx = '0;
        for (int k = 0; k < N_DOM; k++) begin
            if (!w_gnt_vld && r_gap == '0 && w_pend[(int'(r_ptr) + k) % N_DOM]) begin
                w_gnt_vld = 1'b1;
                w_gnt_idx = PW'((int'(r_ptr) + k) % N_DOM);
            end
        end
    end

    assign w_grant = w_gnt_vld ? (N_DOM'(1) << w_gnt_idx) : '0;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_ptr <= '0;
            r_gap <= '0;
        end else if (w_gnt_vld) begin
            r_gap <= GW'(WAKE_GAP);
            r_ptr <= (w_gnt_idx == PW'(N_DOM - 1)) ? '0 : w_gnt_idx + 1'b1;
        end else if (r_gap != '0) begin
            r_gap <= r_gap - 1'b1;
        end
    end

`ifdef CLK_GATE_SEQ_FORCE_ON_EN
    assign EN = w_en | {N_DOM{FORCE_ON}};
`else
    assign EN = w_en;
`endif
endmodule

// File: tb/tb_clk_gate_seq.sv
// tb_clk_gate_seq: randomized and directed checks of clk_gate_seq against a behavioural model
module tb_clk_gate_seq;
    localparam int N    = 4;
    localparam int IDLE = 16;
    localparam int GAP  = 2;

    logic         CLK = 1'b0;
    logic         RST = 1'b1;
    logic [N-1:0] REQ = '0;
    logic [N-1:0] EN, ACK;

    int n_chk = 0;
    int n_err = 0;

    // model: cycles since grant (-1 = gate off), remaining idle cycles (-1 = demand present)
    int m_age [N];
    int m_idle[N];
    bit m_pend[N];
    int m_gap, m_ptr;

    clk_gate_seq #(.N_DOM(N), .IDLE_CYC(IDLE), .WAKE_GAP(GAP)) dut (
        .CLK (CLK),
        .RST (RST),
        .REQ (REQ),
        .EN  (EN),
        .ACK (ACK)
    );

    always #5 CLK = ~CLK;

    function automatic logic [N-1:0] m_en();
        logic [N-1:0] v;
        for (int d = 0; d < N; d++) v[d] = (m_age[d] >= 0);
        return v;
    endfunction

    function automatic logic [N-1:0] m_ack();
        logic [N-1:0] v;
        for (int d = 0; d < N; d++) v[d] = (m_age[d] >= 1);
        return v;
    endfunction

    task automatic model_edge();
        int g;
        g = -1;
        if (RST) begin
            for (int d = 0; d < N; d++) begin
                m_age[d]  = -1;
                m_idle[d] = -1;
                m_pend[d] = 0;
            end
            m_gap = 0;
            m_ptr = 0;
            return;
        end
        if (m_gap == 0)
            for (int k = 0; k < N; k++)
                if (g < 0 && m_pend[(m_ptr + k) % N]) g = (m_ptr + k) % N;
        for (int d = 0; d < N; d++) begin
            if (m_age[d] < 0) begin
                if (m_pend[d]) begin
                    if (d == g) begin
                        m_pend[d] = 0;
                        m_age[d]  = 0;
                    end else if (!REQ[d]) m_pend[d] = 0;
                end else if (REQ[d]) m_pend[d] = 1;
            end else if (m_age[d] == 0) m_age[d] = 1;
            else if (m_idle[d] < 0) begin
                if (!REQ[d]) m_idle[d] = IDLE - 1;
            end else if (REQ[d]) m_idle[d] = -1;
            else if (m_idle[d] == 0) begin
                m_age[d]  = -1;
                m_idle[d] = -1;
            end else m_idle[d]--;
        end
        if (g >= 0) begin
            m_gap = GAP;
            m_ptr = (g + 1) % N;
        end else if (m_gap > 0) m_gap--;
    endtask

    task automatic step();
        @(posedge CLK);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        REQ = '0;
        step();
        RST = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        REQ = 4'b1111;
        for (int k = 0; k < 2; k++) begin
            step();
            n_chk++;
            if (EN !== 4'b0000 || ACK !== 4'b0000) begin
                n_err++;
                $display("FAIL reset_hold en=%b ack=%b want 0000/0000", EN, ACK);
            end
        end
        RST = 1'b0;
        step();
        n_chk++;
        if (EN !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_pend en=%b want 0000", EN);
        end
        step();
        n_chk++;
        if (EN !== 4'b0001 || ACK !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_first_grant en=%b ack=%b want 0001/0000", EN, ACK);
        end
    endtask

    task automatic test_single_wake();
        logic [N-1:0] exp_en[3] = '{4'b0000, 4'b0010, 4'b0010};
        logic [N-1:0] exp_ack[3] = '{4'b0000, 4'b0000, 4'b0010};
        do_reset();
        for (int k = 0; k < 5; k++) step();
        REQ = 4'b0010;
        for (int k = 0; k < 3; k++) begin
            step();
            n_chk++;
            if (EN !== exp_en[k] || ACK !== exp_ack[k]) begin
                n_err++;
                $display("FAIL single_wake[%0d] en=%b ack=%b want %b/%b", k, EN, ACK, exp_en[k], exp_ack[k]);
            end
        end
    endtask

    task automatic test_staggered();
        logic [N-1:0] ee, ea;
        do_reset();
        REQ = 4'b1111;
        step();
        for (int k = 1; k <= 12; k++) begin
            step();
            for (int d = 0; d < N; d++) begin
                ee[d] = (k >= 1 + 3 * d);
                ea[d] = (k >= 2 + 3 * d);
            end
            n_chk++;
            if (EN !== ee || ACK !== ea) begin
                n_err++;
                $display("FAIL staggered[%0d] en=%b ack=%b want %b/%b", k, EN, ACK, ee, ea);
            end
        end
    endtask

    task automatic test_idle_hold();
        logic [N-1:0] ev;
        do_reset();
        REQ = 4'b0100;
        for (int k = 0; k < 3; k++) step();
        REQ = 4'b0000;
        for (int k = 0; k < 18; k++) begin
            step();
            ev = (k < IDLE) ? 4'b0100 : 4'b0000;
            n_chk++;
            if (EN !== ev || ACK !== ev) begin
                n_err++;
                $display("FAIL idle_hold[%0d] en=%b ack=%b want %b/%b", k, EN, ACK, ev, ev);
            end
        end
    endtask

    task automatic test_rereq_hold();
        do_reset();
        REQ = 4'b0100;
        for (int k = 0; k < 3; k++) step();
        REQ = 4'b0000;
        for (int k = 0; k < 28; k++) begin
            if (k == 8) REQ = 4'b0100;
            step();
            n_chk++;
            if (EN !== 4'b0100 || ACK !== 4'b0100) begin
                n_err++;
                $display("FAIL rereq_hold[%0d] en=%b ack=%b want 0100/0100", k, EN, ACK);
            end
        end
        REQ = 4'b0101;
        step();
        step();
        n_chk++;
        if (EN !== 4'b0101) begin
            n_err++;
            $display("FAIL rereq_no_grant_used en=%b want 0101", EN);
        end
    endtask

    task automatic test_cancel_reset();
        do_reset();
        REQ = 4'b0011;
        step();
        step();
        REQ = 4'b1011;
        step();
        REQ = 4'b0011;
        for (int k = 0; k < 2; k++) begin
            step();
            n_chk++;
            if (EN[3] !== 1'b0) begin
                n_err++;
                $display("FAIL cancel_en3[%0d] en=%b want bit3=0", k, EN);
            end
        end
        n_chk++;
        if (EN !== 4'b0011) begin
            n_err++;
            $display("FAIL cancel_next_grant en=%b want 0011", EN);
        end
        REQ = 4'b1111;
        for (int k = 0; k < 3; k++) step();
        n_chk++;
        if (EN !== 4'b0111) begin
            n_err++;
            $display("FAIL cancel_ptr en=%b want 0111", EN);
        end
        for (int k = 0; k < 4; k++) step();
        REQ = 4'b0000;
        for (int k = 0; k < 5; k++) step();
        n_chk++;
        if (EN !== 4'b1111 || ACK !== 4'b1111) begin
            n_err++;
            $display("FAIL hold_before_rst en=%b ack=%b want 1111/1111", EN, ACK);
        end
        RST = 1'b1;
        step();
        n_chk++;
        if (EN !== 4'b0000 || ACK !== 4'b0000) begin
            n_err++;
            $display("FAIL rst_mid_hold en=%b ack=%b want 0000/0000", EN, ACK);
        end
        RST = 1'b0;
    endtask

    task automatic test_random();
        int bad;
        bad = 0;
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            for (int d = 0; d < N; d++)
                if ($urandom_range(7) == 0) REQ[d] = ~REQ[d];
            RST = ($urandom_range(199) == 0);
            step();
            n_chk++;
            if (EN !== m_en() || ACK !== m_ack()) begin
                n_err++;
                if (bad++ < 10)
                    $display("FAIL random[%0d] en=%b ack=%b want %b/%b", k, EN, ACK, m_en(), m_ack());
            end
        end
        RST = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_wake();
        test_staggered();
        test_idle_hold();
        test_rereq_hold();
        test_cancel_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/clk_gate_seq.md
CLK_GATE_SEQ -- requirements
Module: clk_gate_seq

Interface
REQ-001 SHALL have parameter N_DOM, default 4: number of gated clock domains (1..16).
REQ-002 SHALL have parameter IDLE_CYC, default 16: cycles a domain clock stays enabled after its REQ drops (1..65535).
REQ-003 SHALL have parameter WAKE_GAP, default 2: minimum idle cycles between successive wake grants (0..255).
REQ-004 SHALL have port CLK  input  1  the single clock for all logic.
REQ-005 SHALL have port RST  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port REQ  input  N_DOM  per-domain clock demand, level-sensitive.
REQ-007 SHALL have port EN  output  N_DOM  per-domain enable, driving the EN input of one clock gate cell each.
REQ-008 SHALL have port ACK  output  N_DOM  per-domain "gated clock running" indication.

Function
REQ-009 SHALL run one FSM per domain with states OFF, PEND, WAKE, ON and HOLD.
REQ-010 SHALL decode outputs from state only: EN=1 in WAKE/ON/HOLD; ACK=1 in ON/HOLD.
REQ-011 OFF: REQ=1 -> PEND; otherwise stay.
REQ-012 PEND: if granted -> WAKE; else if REQ=0 -> OFF (cancel); else stay.
REQ-013 WAKE: -> ON unconditionally after exactly one cycle, regardless of REQ.
REQ-014 ON: REQ=0 -> HOLD, loading the idle counter with IDLE_CYC-1.
REQ-015 HOLD: if REQ=1 -> ON, with no EN/ACK deassertion; else if counter=0 -> OFF; else decrement.
REQ-016 SHALL grant at most one PEND domain per cycle, using round-robin starting from the index after the last granted domain.
REQ-017 After a grant, a gap counter SHALL load WAKE_GAP; no grant while it is nonzero; WAKE_GAP=0 allows grants on consecutive cycles.
REQ-018 Uncontended latency: REQ sampled high at edge t -> PEND after t, EN after t+1, ACK after t+2.
REQ-019 A cancelled PEND SHALL neither consume a grant nor advance the round-robin pointer.
REQ-020 Counter and arithmetic widths SHALL be $clog2 of parameter+1; counters SHALL never wrap below zero.

Reset
REQ-021 RST=1 at an edge SHALL force all FSMs to OFF, EN=0, ACK=0, gap counter=0, idle counters=0 and round-robin pointer=0 after that edge.
REQ-022 Reset SHALL override every state, including mid-WAKE and mid-HOLD; REQ is ignored while RST=1.

Configuration
REQ-023 With macro CLK_GATE_SEQ_FORCE_ON_EN defined, SHALL add input port FORCE_ON (1 bit), with EN = FSM enable OR FORCE_ON, combinationally.
REQ-024 FORCE_ON SHALL affect neither FSM state, ACK, nor arbitration.
REQ-025 Without the macro, the FORCE_ON port SHALL be absent and EN SHALL equal the FSM enable.

Structure
REQ-026 Package clk_gate_seq_pkg SHALL hold the domain-state enum typedef and the default parameter constants.
REQ-027 The per-domain FSM plus idle counter SHALL be sub-module clk_gate_seq_dom, instantiated N_DOM times by generate.
REQ-028 The round-robin arbiter and gap counter SHALL reside in the top module.

Verification (N_DOM=4, IDLE_CYC=16, WAKE_GAP=2)
REQ-029 Reset: RST=1 for 2 cycles with REQ=4'b1111 -> EN=0, ACK=0 throughout; after release, domain 0 is granted first.
REQ-030 Single wake: REQ[1] rises before edge 10 -> EN[1]=1 after edge 11, ACK[1]=1 after edge 12, other bits stay 0.
REQ-031 Staggered wake: REQ=4'b1111 from edge 0 -> EN[0..3] rise after edges 1, 4, 7, 10 respectively.
REQ-032 Idle hold: REQ[2] drops while ON -> EN[2]/ACK[2] stay 1 for 16 cycles, then both drop together.
REQ-033 Re-request in HOLD: REQ[2] re-rises 8 cycles into HOLD -> EN[2]/ACK[2] never drop and no grant is consumed.
REQ-034 Cancel and reset: REQ[3] pulses 1 cycle while the gap blocks -> EN[3] is never asserted and the pointer is unchanged; RST mid-HOLD -> all outputs 0 after that edge.
